lfsr26: RTL and testbench

//  - Loadable 26-bit Fibonacci LFSR that generates a maximal-length pseudo-random sequence.
//  - Feedback polynomial: x^26 + x^6 + x^2 + x + 1 (period 2^26-1).
//  - Pattern/scrambler source for DSD datapath blocks.
//  - Supports parallel seed load.

---
 rtl/lfsr26.sv | 44 ++++
 tb/tb_lfsr26.sv | 136 +++++++++++++
 2 files changed

// File: rtl/lfsr26.sv
// rtl/lfsr26.sv - loadable 26-bit Fibonacci LFSR, x^26 + x^6 + x^2 + x + 1
// Bits are numbered 1..WIDTH with q[1] the MSB; each step shifts toward q[WIDTH].
module lfsr26 #(
   parameter int               WIDTH = 26,
   parameter logic [WIDTH-1:0] TAPS  = 26'h2000023,
   parameter logic [WIDTH-1:0] SEED  = 26'd1
) (
   output logic [1:WIDTH] q,
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic [1:WIDTH] din
);

   logic [1:WIDTH] state_q;
   logic [1:WIDTH] state_d;
   logic [1:WIDTH] tap_v;
   logic           fb;

   always_comb begin
      tap_v = '0;
      // Mask bit k-1 selects tap k, which is state bit q[k].
      for (int k = 1; k <= WIDTH; k++) begin
         tap_v[k] = TAPS[k-1];
      end
      fb      = ^(state_q & tap_v);
      state_d = {fb, state_q[1:WIDTH-1]};
      if (load) begin
         // The all-zero state would lock up, so a zero seed loads SEED instead.
         state_d = (din == '0) ? SEED : din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign q = state_q;

endmodule

// File: tb/tb_lfsr26.sv
// tb/tb_lfsr26.sv - self-checking bench for lfsr26
// Directed vector table, hand-written reset sequences and a randomized run against an integer model.
module tb_lfsr26;

   logic        clk;
   logic        rst;
   logic        load;
   logic [1:26] din;
   logic [1:26] q;

   int errors = 0;
   int checks = 0;

   lfsr26 dut (
      .q    (q),
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .din  (din)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ld;
      logic [25:0] d;
      logic [25:0] exp;
   } vec_t;

   vec_t vecs[$];

   // Model: state as an unsigned value with q[26] as bit 0; taps q[26],q[6],q[2],q[1]
   // are value bits 0,20,24,25. New bit enters at the top as the value halves.
   function automatic logic [25:0] model_step(input logic [25:0] v);
      int fb;
      fb = $countones(v & 26'h3100001) % 2;
      return (v >> 1) + (fb != 0 ? 26'd33554432 : 26'd0);
   endfunction

   task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic edge_and_check(input string name, input logic [25:0] exp);
      @(posedge clk);
      #1;
      check(name, q, exp);
   endtask

   logic [25:0] model;
   logic [25:0] qv;

   initial begin
      rst  = 1'b0;
      load = 1'b0;
      din  = '0;

      // Asynchronous reset between edges
      @(posedge clk);
      #1 rst = 1'b1;
      #1 check("reset_async", q, 26'd1);
      @(posedge clk);
      #1 check("reset_hold", q, 26'd1);
      rst = 1'b0;
      edge_and_check("reset_step1", 26'd33554432);
      edge_and_check("reset_step2", 26'd50331648);

      // Directed table, applied one edge per entry, continuing from the state above
      vecs.push_back('{1'b1, 26'd26, 26'd26});
      vecs.push_back('{1'b0, 26'd0,  26'd13});
      vecs.push_back('{1'b0, 26'd0,  26'd33554438});
      vecs.push_back('{1'b1, 26'd26, 26'd26});
      vecs.push_back('{1'b1, 26'd26, 26'd26});
      vecs.push_back('{1'b1, 26'd26, 26'd26});
      vecs.push_back('{1'b1, 26'd0,  26'd1});
      vecs.push_back('{1'b1, 26'd0,  26'd1});
      vecs.push_back('{1'b0, 26'd0,  26'd33554432});
      vecs.push_back('{1'b1, 26'h3FFFFFF, 26'h3FFFFFF});
      vecs.push_back('{1'b0, 26'd0,  26'h1FFFFFF});
      for (int i = 0; i < vecs.size(); i++) begin
         load = vecs[i].ld;
         din  = vecs[i].d;
         edge_and_check($sformatf("table[%0d]", i), vecs[i].exp);
      end
      load = 1'b0;
      din  = '0;

      // Mid-run reset after 10 steps: 5 ns pulse between edges, then identical restart
      for (int i = 0; i < 10; i++) @(posedge clk);
      #1 rst = 1'b1;
      #2 check("midrun_reset_async", q, 26'd1);
      #3 rst = 1'b0;
      edge_and_check("midrun_step1", 26'd33554432);
      edge_and_check("midrun_step2", 26'd50331648);

      // Free run from SEED: never zero, never back to SEED within the window
      @(posedge clk);
      #1 rst = 1'b1;
      #2 rst = 1'b0;
      model = 26'd1;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         #1;
         model = model_step(model);
         qv = q;
         check("freerun_model", qv, model);
         checks++;
         if (qv == 26'd0 || qv == 26'd1) begin
            errors++;
            $display("FAIL freerun_early_wrap: got %0d at step %0d expected neither 0 nor 1", qv, i + 1);
         end
      end

      // Randomized loads, zero seeds and steps against the model
      for (int i = 0; i < 3000; i++) begin
         load = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 3))
            0:       din = '0;
            default: din = 26'($urandom);
         endcase
         if (load) model = (din == '0) ? 26'd1 : din;
         else      model = model_step(model);
         edge_and_check("random_model", model);
      end
      load = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
